// File: rtl/reel_bank_if.sv
// Handshake and status bundle between the button/tick logic, the reel controller and the VGA address generator.
interface reel_bank_if #(
  parameter int N_REELS = 3,
  parameter int POS_W   = 10,
  parameter int SYM_W   = 2
);
  logic                       tick;
  logic                       start;
  logic                       dir;
  logic [N_REELS*POS_W-1:0]   pos;
  logic [N_REELS*SYM_W-1:0]   sym;
  logic                       dir_q;
  logic                       busy;
  logic                       done;
  logic                       match;

  modport master (output tick, start, dir,
                  input  pos, sym, dir_q, busy, done, match);
  modport slave  (input  tick, start, dir,
                  output pos, sym, dir_q, busy, done, match);
endinterface

// File: rtl/reel_bank_ctrl.sv
// N-reel spin controller: shared SLOW/MID/FAST schedule, staggered per-reel decel, symbol-boundary snap.
module reel_bank_ctrl #(
  parameter int N_REELS  = 3,
  parameter int POS_W    = 10,
  parameter int IMG_H    = 240,
  parameter int SYM_H    = 60,
  parameter int SYM_W    = 2,
  parameter int SPD_SLOW = 1,
  parameter int SPD_MID  = 2,
  parameter int SPD_FAST = 3,
  parameter int T_MID    = 240,
  parameter int T_FAST   = 360,
  parameter int T_DECEL  = 440,
  parameter int STAGGER  = 160,
  parameter int T_RAMP   = 120,
  parameter int CNT_W    = 11
) (
  input  logic        clk,
  input  logic        rst,
  reel_bank_if.slave  bus
);

  localparam int               N_SYM    = IMG_H / SYM_H;
  localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(N_SYM - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [POS_W-1:0] IMG_LEN  = POS_W'(IMG_H);
  localparam logic [POS_W-1:0] SYM_LEN  = POS_W'(SYM_H);

  typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_ALIGN} reel_state_e;

  reel_state_e      state_q [N_REELS];
  reel_state_e      state_d [N_REELS];
  logic [POS_W-1:0] pos_q   [N_REELS];
  logic [POS_W-1:0] pos_d   [N_REELS];
  logic [POS_W-1:0] off_q   [N_REELS];
  logic [POS_W-1:0] off_d   [N_REELS];
  logic [SYM_W-1:0] sym_q   [N_REELS];
  logic [SYM_W-1:0] sym_d   [N_REELS];
  logic [POS_W-1:0] spd     [N_REELS];

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic             pdir_q, pdir_d;
  logic             dir_q, dir_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             match_q, match_d;
  logic             all_stop, all_match;

  // Speed a RUN reel uses at schedule count cnt; beyond the SLOW ramp it keeps SLOW for the ALIGN hand-off tick.
  function automatic logic [POS_W-1:0] run_speed(input logic [CNT_W-1:0] cnt, input int idx);
    int c;
    int e;
    c = int'(cnt);
    e = T_DECEL + idx * STAGGER;
    if (c >= e + T_RAMP)   run_speed = POS_W'(SPD_SLOW);
    else if (c >= e)       run_speed = POS_W'(SPD_MID);
    else if (c >= T_FAST)  run_speed = POS_W'(SPD_FAST);
    else if (c >= T_MID)   run_speed = POS_W'(SPD_MID);
    else                   run_speed = POS_W'(SPD_SLOW);
  endfunction

  always_comb begin
    // NOTE: every next-state signal starts from its held value so no path leaves it unassigned (no latches).
    cnt_d     = cnt_q;
    pending_d = pending_q;
    pdir_d    = pdir_q;
    dir_d     = dir_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    match_d   = match_q;
    all_stop  = 1'b1;
    all_match = 1'b1;
    for (int i = 0; i < N_REELS; i++) begin
      state_d[i] = state_q[i];
      pos_d[i]   = pos_q[i];
      off_d[i]   = off_q[i];
      sym_d[i]   = sym_q[i];
      spd[i]     = '0;
    end

    if (bus.tick) begin
      if (pending_q) begin
        pending_d = 1'b0;
        dir_d     = pdir_q;
        cnt_d     = '0;
        busy_d    = 1'b1;
        match_d   = 1'b0;
        for (int i = 0; i < N_REELS; i++) state_d[i] = ST_RUN;
      end else if (busy_q) begin
        for (int i = 0; i < N_REELS; i++) begin
          case (state_q[i])
            ST_RUN: begin
              spd[i] = run_speed(cnt_q, i);
              if (int'(cnt_q) >= T_DECEL + i * STAGGER + 2 * T_RAMP) state_d[i] = ST_ALIGN;
            end
            ST_ALIGN: begin
              if (off_q[i] == '0) state_d[i] = ST_STOP;
              else                spd[i]     = POS_W'(SPD_SLOW);
            end
            default: ;
          endcase

          // Offset within the symbol and symbol index track the position without a divider.
          if (dir_q) begin
            pos_d[i] = (pos_q[i] < spd[i]) ? pos_q[i] + (IMG_LEN - spd[i]) : pos_q[i] - spd[i];
            if (off_q[i] < spd[i]) begin
              off_d[i] = off_q[i] + (SYM_LEN - spd[i]);
              sym_d[i] = (sym_q[i] == '0) ? SYM_LAST : sym_q[i] - SYM_W'(1);
            end else begin
              off_d[i] = off_q[i] - spd[i];
            end
          end else begin
            pos_d[i] = (pos_q[i] >= IMG_LEN - spd[i]) ? pos_q[i] - (IMG_LEN - spd[i]) : pos_q[i] + spd[i];
            if (off_q[i] >= SYM_LEN - spd[i]) begin
              off_d[i] = off_q[i] - (SYM_LEN - spd[i]);
              sym_d[i] = (sym_q[i] == SYM_LAST) ? '0 : sym_q[i] + SYM_W'(1);
            end else begin
              off_d[i] = off_q[i] + spd[i];
            end
          end

          if (state_d[i] != ST_STOP) all_stop = 1'b0;
          if (sym_d[i] != sym_d[0])  all_match = 1'b0;
        end

        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        if (all_stop) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          match_d = all_match;
        end
      end
    end

    // A request only latches while idle; it is consumed by the next tick.
    if (bus.start && !busy_q && !pending_q) begin
      pending_d = 1'b1;
      pdir_d    = bus.dir;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the per-reel arrays are motion state rather than storage, so they reset with everything else.
    if (rst) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
      pdir_q    <= 1'b0;
      dir_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      match_q   <= 1'b0;
      for (int i = 0; i < N_REELS; i++) begin
        state_q[i] <= ST_STOP;
        pos_q[i]   <= '0;
        off_q[i]   <= '0;
        sym_q[i]   <= '0;
      end
    end else begin
      // NOTE: state updates are non-blocking so every register samples the same pre-edge values.
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      pdir_q    <= pdir_d;
      dir_q     <= dir_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      match_q   <= match_d;
      for (int i = 0; i < N_REELS; i++) begin
        state_q[i] <= state_d[i];
        pos_q[i]   <= pos_d[i];
        off_q[i]   <= off_d[i];
        sym_q[i]   <= sym_d[i];
      end
    end
  end

  for (genvar g = 0; g < N_REELS; g++) begin : g_out
    assign bus.pos[g*POS_W +: POS_W] = pos_q[g];
    assign bus.sym[g*SYM_W +: SYM_W] = sym_q[g];
  end

  assign bus.dir_q = dir_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.match = match_q;

endmodule

// File: tb/tb_reel_bank_ctrl.sv
// Drives a default-sized and a small 4-reel controller in lockstep and checks both against a spin model.
module tb_reel_bank_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reel_bank_if #(.N_REELS(3), .POS_W(10), .SYM_W(2)) ifa ();
  reel_bank_if #(.N_REELS(4), .POS_W(10), .SYM_W(2)) ifb ();

  reel_bank_ctrl dut_a (.clk(clk), .rst(rst), .bus(ifa));

  reel_bank_ctrl #(
    .N_REELS(4), .POS_W(10), .IMG_H(24), .SYM_H(6), .SYM_W(2),
    .T_MID(4), .T_FAST(6), .T_DECEL(8), .STAGGER(3), .T_RAMP(2)
  ) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Spin model: absolute positions with modular arithmetic, symbols by division. Index 0 = dut_a, 1 = dut_b.
  localparam int P_STOP = 0, P_RUN = 1, P_ALIGN = 2;
  int c_n[2]     = '{3, 4};
  int c_img[2]   = '{240, 24};
  int c_symh[2]  = '{60, 6};
  int c_tmid[2]  = '{240, 4};
  int c_tfast[2] = '{360, 6};
  int c_tdec[2]  = '{440, 8};
  int c_stag[2]  = '{160, 3};
  int c_ramp[2]  = '{120, 2};

  bit m_busy[2], m_pend[2], m_pdir[2], m_dir[2], m_done[2], m_match[2];
  int m_cnt[2];
  int m_spins[2];
  int m_phase[2][4];
  int m_pos[2][4];

  function automatic int sched(input int m, input int i, input int c);
    int e;
    e = c_tdec[m] + i * c_stag[m];
    if (c < c_tmid[m])                        return 1;
    if (c < c_tfast[m] && c < e)              return 2;
    if (c < e)                                return 3;
    if (c < e + c_ramp[m])                    return 2;
    return 1;
  endfunction

  task automatic model_step(input int m, input bit r, input bit t, input bit s, input bit d);
    bit acc, all_stop, same;
    int spd;
    acc = s && !m_busy[m] && !m_pend[m];
    if (r) begin
      m_busy[m] = 0; m_pend[m] = 0; m_pdir[m] = 0; m_dir[m] = 0;
      m_done[m] = 0; m_match[m] = 0; m_cnt[m] = 0;
      for (int i = 0; i < 4; i++) begin
        m_phase[m][i] = P_STOP;
        m_pos[m][i]   = 0;
      end
    end else begin
      m_done[m] = 0;
      if (t && m_pend[m]) begin
        m_pend[m]  = 0;
        m_dir[m]   = m_pdir[m];
        m_cnt[m]   = 0;
        m_busy[m]  = 1;
        m_match[m] = 0;
        m_spins[m]++;
        for (int i = 0; i < c_n[m]; i++) m_phase[m][i] = P_RUN;
      end else if (t && m_busy[m]) begin
        all_stop = 1;
        for (int i = 0; i < c_n[m]; i++) begin
          spd = 0;
          if (m_phase[m][i] == P_RUN) begin
            spd = sched(m, i, m_cnt[m]);
            if (m_cnt[m] >= c_tdec[m] + i * c_stag[m] + 2 * c_ramp[m]) m_phase[m][i] = P_ALIGN;
          end else if (m_phase[m][i] == P_ALIGN) begin
            if (m_pos[m][i] % c_symh[m] == 0) m_phase[m][i] = P_STOP;
            else spd = 1;
          end
          m_pos[m][i] = ((m_dir[m] ? m_pos[m][i] - spd : m_pos[m][i] + spd) + c_img[m]) % c_img[m];
          if (m_phase[m][i] != P_STOP) all_stop = 0;
        end
        if (m_cnt[m] < 2047) m_cnt[m]++;
        if (all_stop) begin
          same = 1;
          for (int i = 1; i < c_n[m]; i++)
            if (m_pos[m][i] / c_symh[m] != m_pos[m][0] / c_symh[m]) same = 0;
          m_busy[m]  = 0;
          m_done[m]  = 1;
          m_match[m] = same;
        end
      end
      if (acc) begin
        m_pend[m] = 1;
        m_pdir[m] = d;
      end
    end
  endtask

  task automatic compare_all();
    logic [29:0] ea_pos;
    logic [5:0]  ea_sym;
    logic [39:0] eb_pos;
    logic [7:0]  eb_sym;
    ea_pos = '0; ea_sym = '0; eb_pos = '0; eb_sym = '0;
    for (int i = 0; i < 3; i++) begin
      ea_pos[i*10 +: 10] = 10'(m_pos[0][i]);
      ea_sym[i*2 +: 2]   = 2'(m_pos[0][i] / 60);
    end
    for (int i = 0; i < 4; i++) begin
      eb_pos[i*10 +: 10] = 10'(m_pos[1][i]);
      eb_sym[i*2 +: 2]   = 2'(m_pos[1][i] / 6);
    end
    check("a_pos",   64'(ifa.pos),   64'(ea_pos));
    check("a_sym",   64'(ifa.sym),   64'(ea_sym));
    check("a_busy",  64'(ifa.busy),  64'(m_busy[0]));
    check("a_done",  64'(ifa.done),  64'(m_done[0]));
    check("a_match", 64'(ifa.match), 64'(m_match[0]));
    check("a_dir_q", 64'(ifa.dir_q), 64'(m_dir[0]));
    check("b_pos",   64'(ifb.pos),   64'(eb_pos));
    check("b_sym",   64'(ifb.sym),   64'(eb_sym));
    check("b_busy",  64'(ifb.busy),  64'(m_busy[1]));
    check("b_done",  64'(ifb.done),  64'(m_done[1]));
    check("b_match", 64'(ifb.match), 64'(m_match[1]));
    check("b_dir_q", 64'(ifb.dir_q), 64'(m_dir[1]));
  endtask

  int          cyc_n = 0;
  int          done_a = 0;
  int          done_b = 0;
  int          last_chg[3];
  logic [29:0] prev_pos_a = '0;

  // One clock: drive at the falling edge, sample 1 ns after the rising edge.
  task automatic cyc(input bit r, input bit t, input bit s, input bit d);
    @(negedge clk);
    rst = r;
    ifa.tick = t; ifa.start = s; ifa.dir = d;
    ifb.tick = t; ifb.start = s; ifb.dir = d;
    @(posedge clk);
    #1;
    cyc_n++;
    model_step(0, r, t, s, d);
    model_step(1, r, t, s, d);
    compare_all();
    if (ifa.done) done_a++;
    if (ifb.done) done_b++;
    for (int i = 0; i < 3; i++)
      if (ifa.pos[i*10 +: 10] != prev_pos_a[i*10 +: 10]) last_chg[i] = cyc_n;
    prev_pos_a = ifa.pos;
  endtask

  // One tick cycle followed by gap idle cycles; with rnd set, stray starts are thrown in while a spin is live.
  task automatic tick_period(input int gap, input bit rnd);
    bit s;
    s = rnd && (m_busy[0] || m_pend[0]) && ($urandom_range(0, 3) == 0);
    cyc(1'b0, 1'b1, s, 1'($urandom_range(0, 1)));
    for (int g = 0; g < gap; g++) begin
      s = rnd && (m_busy[0] || m_pend[0]) && ($urandom_range(0, 3) == 0);
      cyc(1'b0, 1'b0, s, 1'($urandom_range(0, 1)));
    end
  endtask

  typedef struct packed {
    logic       rst, tick, start, dir;
    logic       e_busy, e_dir_q, e_done;
    logic [9:0] e_pos0;
  } vec_t;

  vec_t vecs[14];
  bit   seen238;

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd239};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'd238};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd237};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd1};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'd1};

    rst = 1'b1;
    ifa.tick = 1'b0; ifa.start = 1'b0; ifa.dir = 1'b0;
    ifb.tick = 1'b0; ifb.start = 1'b0; ifb.dir = 1'b0;

    // Short hand-computed sequences: reset, start latency, first SLOW steps, ignored start, mid-spin reset.
    for (int k = 0; k < 14; k++) begin
      cyc(vecs[k].rst, vecs[k].tick, vecs[k].start, vecs[k].dir);
      check($sformatf("vec%0d_busy", k),  64'(ifa.busy),           64'(vecs[k].e_busy));
      check($sformatf("vec%0d_dir_q", k), 64'(ifa.dir_q),          64'(vecs[k].e_dir_q));
      check($sformatf("vec%0d_done", k),  64'(ifa.done),           64'(vecs[k].e_done));
      check($sformatf("vec%0d_pos0", k),  64'(ifa.pos[9:0]),       64'(vecs[k].e_pos0));
    end

    // Reset while spinning at cnt=500.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 1000 && m_cnt[0] != 500; k++) tick_period(3, 1'b0);
    if (m_cnt[0] != 500) begin
      total++; bad++;
      $display("FAIL cnt500_timeout: got %0d expected 500", m_cnt[0]);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("rst500_pos",   64'(ifa.pos),   64'd0);
    check("rst500_sym",   64'(ifa.sym),   64'd0);
    check("rst500_busy",  64'(ifa.busy),  64'd0);
    check("rst500_match", 64'(ifa.match), 64'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      check($sformatf("rst500_nodone%0d", k), 64'(ifa.done), 64'd0);
    end

    // Full spin, dir=0, tick every 4 clocks.
    done_a = 0;
    for (int i = 0; i < 3; i++) last_chg[i] = 0;
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 1500 && (m_busy[0] || m_pend[0]); k++) tick_period(3, 1'b0);
    check("spin0_idle",       64'(ifa.busy), 64'd0);
    check("spin0_done_count", 64'(done_a),   64'd1);
    check("spin0_order01",    64'(last_chg[0] < last_chg[1]), 64'd1);
    check("spin0_order12",    64'(last_chg[1] < last_chg[2]), 64'd1);
    for (int i = 0; i < 3; i++)
      check($sformatf("spin0_aligned%0d", i), 64'(ifa.pos[i*10 +: 10]) % 64'd60, 64'd0);

    // Spin dir=1 from reset, random tick spacing, stray starts while busy; the small DUT spins repeatedly.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    done_a = 0; done_b = 0; m_spins[1] = 0;
    seen238 = 1'b0;
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 1500 && (m_busy[0] || m_pend[0]); k++) begin
      tick_period($urandom_range(0, 3), 1'b1);
      if (!seen238 && m_cnt[0] == 241) begin
        check("spin1_first_mid_pos0", 64'(ifa.pos[9:0]), 64'd238);
        seen238 = 1'b1;
      end
    end
    if (!seen238) begin
      total++; bad++;
      $display("FAIL spin1_first_mid_pos0: got no MID tick expected 238");
    end
    check("spin1_idle",       64'(ifa.busy),  64'd0);
    check("spin1_dir_q",      64'(ifa.dir_q), 64'd1);
    check("spin1_done_count", 64'(done_a),    64'd1);

    for (int k = 0; k < 200 && (m_busy[1] || m_pend[1]); k++) tick_period(1, 1'b0);
    check("b_idle",       64'(ifb.busy), 64'd0);
    check("b_done_count", 64'(done_b),   64'(m_spins[1]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/reel_bank_ctrl.md
# reel_bank_ctrl

Parametrised motion controller for an N-reel slot machine display. A single start request spins all reels with a SLOW→MID→FAST→MID→SLOW speed profile, and each reel's stop point is staggered. Every reel is snapped to a symbol boundary before it stops. The block reports per-reel scroll offsets, the stopped symbol indices, the spin direction, a completion pulse and an all-symbols-match flag. It sits between the button one-pulse logic and the VGA memory address generator, and advances only on a frame-rate `tick` enable.

## Interface
- N_REELS, 3, number of reels
- POS_W, 10, width of each position/offset field
- IMG_H, 240, reel strip height in lines; must be a multiple of SYM_H
- SYM_H, 60, symbol height in lines
- SYM_W, 2, width of each symbol index field; 2^SYM_W ≥ IMG_H/SYM_H
- SPD_SLOW / SPD_MID / SPD_FAST, 1 / 2 / 3, lines per tick; SPD_SLOW must be 1; SPD_FAST < SYM_H
- T_MID, 240, tick count at which MID starts
- T_FAST, 360, tick count at which FAST starts
- T_DECEL, 440, tick count at which reel 0 ends FAST
- STAGGER, 160, extra FAST ticks per reel index
- T_RAMP, 120, ticks spent in each of the MID and SLOW decel stages
- CNT_W, 11, width of the schedule counter
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tick  in  1  one-cycle frame enable; all motion state advances only on cycles where tick=1
- start  in  1  single-cycle spin request
- dir  in  1  spin direction, sampled with start; 0 = position increments, 1 = position decrements
- pos  out  N_REELS*POS_W  per-reel scroll offset, in 0..IMG_H-1; reel i occupies bits [i*POS_W +: POS_W]
- sym  out  N_REELS*SYM_W  per-reel symbol index, equal to pos/SYM_H
- dir_q  out  1  latched direction of the current or last spin
- busy  out  1  high while any reel is not in STOP
- done  out  1  one-cycle pulse when the last reel enters STOP
- match  out  1  high when all sym fields are equal; updated at done

## Operation
- Per-reel FSM states:
  - STOP (speed 0)
  - RUN (speed taken from the schedule)
  - ALIGN (speed SPD_SLOW)
- Schedule counter `cnt`:
  - cleared when a start is accepted
  - increments by 1 on each tick while busy
  - saturates at 2^CNT_W-1
- Reel i stop point: E_i = T_DECEL + i*STAGGER.
- RUN speed as a function of cnt:
  - cnt < T_MID: SLOW
  - T_MID ≤ cnt < T_FAST: MID
  - T_FAST ≤ cnt < E_i: FAST
  - E_i ≤ cnt < E_i+T_RAMP: MID
  - E_i+T_RAMP ≤ cnt < E_i+2*T_RAMP: SLOW
  - cnt ≥ E_i+2*T_RAMP: transition to ALIGN
  - If E_i ≤ T_FAST, the FAST stage is skipped.
- ALIGN behaviour:
  - if the reel's offset within its symbol is 0, go to STOP with no movement on that tick
  - otherwise advance by 1 line
- Start acceptance:
  - A start arriving with busy=0 sets a pending flag.
  - On the next tick the pending flag is consumed: all reels go STOP→RUN, cnt=0, dir_q=dir (dir is sampled when start arrives).
  - A start arriving while busy=1 or pending=1 is ignored.
- Position update per tick uses the speed of the state held before the transition.
  - Increment: p' = p+s, minus IMG_H if ≥ IMG_H.
  - Decrement: p' = p-s, plus IMG_H if negative.
  - Symbol index and in-symbol offset are maintained incrementally (no divider); sym wraps at IMG_H/SYM_H.
- busy is 1 from the tick that accepts start until the tick on which the last reel enters STOP.
- done and match:
  - done pulses for exactly one clk cycle, on the cycle after the tick on which busy falls.
  - match is registered on that same tick and held until the next accepted start, which clears it to 0.

## Timing
- Reset values:
  - pos = 0, sym = 0
  - dir_q, busy, done, match = 0
  - all reels STOP; cnt = 0; pending = 0
- Reset mid-spin aborts immediately on that edge; no done pulse is produced.
- On cycles with tick=0, all registers hold their value except the pending flag and done (done clears).
- Latency: start → busy=1 takes at most one tick period plus one cycle.
- All outputs are registered.
- Reels stop in index order, because E_i increases with i. Two reels entering STOP on the same tick is legal; done fires only for the last one.
- With defaults, reel i enters ALIGN at cnt = 680 + 160*i, so reel 2 enters ALIGN at cnt 1000, and at most SYM_H-1 ALIGN ticks follow.

## Test plan
- Reset during a spin at cnt=500 → next cycle: pos=0, busy=0, no done pulse, sym=0, match=0.
- Start with dir=0 and defaults, tick every 4 clk cycles:
  - busy=1 one tick after start
  - reel 0 STOP before reel 1, reel 1 before reel 2
  - at done, every pos is a multiple of 60 and sym = pos/60
- Start with dir=1:
  - after the first MID tick, reel 0 pos = 240-(T_MID*1)%240-2, which is 238 from reset
  - dir_q=1 throughout
- Start pulse repeated while busy → ignored; cnt and pos trajectory are identical to a single-start run.
- N_REELS=4, IMG_H=24, SYM_H=6, T_MID=4, T_FAST=6, T_DECEL=8, STAGGER=3, T_RAMP=2:
  - 4 reels stop in order
  - exactly one done pulse
  - match equals the comparison of the four sym values
- Wrap-around: a reel at pos 238 with speed 3 and dir=0 → pos 1 on the next tick, with sym going 3→0.
